// File: rtl/interrupt_sequencer.sv
// Reset/NMI/IRQ/BRK entry sequencer: qualifies and prioritises requests, then walks
// the seven T-states (stack pushes, flag update, vector fetch) that hand control to the vector.
module interrupt_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int RES_MIN_LOW = 2
) (
  input  logic       fclk_i,
  input  logic       rst_i,
  input  logic       rdy_i,
  input  logic       resb_i,
  input  logic       nmib_i,
  input  logic       irqb_i,
  input  logic       i_flag_i,
  input  logic       instr_boundary_i,
  input  logic       brk_req_i,
  output logic       busy_o,
  output logic [2:0] seq_step_o,
  output logic [1:0] cause_o,
  output logic       rwb_o,
  output logic [1:0] stack_sel_o,
  output logic       sp_decrement_o,
  output logic       reset_stack_o,
  output logic       psr_b_value_o,
  output logic       set_i_flag_o,
  output logic       clear_d_flag_o,
  output logic       vpb_o,
  output logic       push_resb_o,
  output logic       push_nmib_o,
  output logic       push_irqb_o,
  output logic       push_vector_o,
  output logic       seq_done_o,
  output logic       nmi_pending_o,
  output logic       irq_pending_o
);

  localparam int CNT_W = $clog2(RES_MIN_LOW + 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_RES_HOLD, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_RES  = 2'b01,
    CAUSE_NMI  = 2'b10,
    CAUSE_IRQ  = 2'b11
  } cause_e;

  state_e                 state_q, state_d;
  cause_e                 cause_q, cause_d;
  logic                   brk_q, brk_d;
  logic                   done_q, done_d;
  logic                   nmi_pend_q, nmi_pend_d;
  logic                   nmi_prev_q, nmi_prev_d;
  logic [SYNC_STAGES-1:0] resb_sync_q, nmib_sync_q, irqb_sync_q;
  logic [CNT_W-1:0]       res_cnt_q, res_cnt_d;

  logic res_low, res_qual, nmi_sync, irq_sync_low, nmi_edge, irq_req, is_res, stack_push;

  assign res_low      = ~resb_sync_q[SYNC_STAGES-1];
  assign nmi_sync     = nmib_sync_q[SYNC_STAGES-1];
  assign irq_sync_low = ~irqb_sync_q[SYNC_STAGES-1];
  assign nmi_edge     = nmi_prev_q & ~nmi_sync;
  assign irq_req      = irq_sync_low & ~i_flag_i;
  assign res_qual     = res_low && (res_cnt_q >= CNT_W'(RES_MIN_LOW - 1));

  // Reset qualification counts synchronised-low samples and is independent of rdy.
  always_comb begin
    res_cnt_d = '0;
    if (res_low) begin
      res_cnt_d = res_cnt_q;
      if (res_cnt_q != CNT_W'(RES_MIN_LOW)) res_cnt_d = res_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    brk_d      = brk_q;
    done_d     = done_q;
    nmi_pend_d = nmi_pend_q;
    nmi_prev_d = nmi_prev_q;
    if (rdy_i) begin
      nmi_prev_d = nmi_sync;
      done_d     = 1'b0;
      if (nmi_edge) nmi_pend_d = 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (instr_boundary_i) begin
            if (nmi_pend_q) begin
              state_d = ST_T1;
              cause_d = CAUSE_NMI;
              brk_d   = 1'b0;
              if (!nmi_edge) nmi_pend_d = 1'b0;
            end else if (irq_req) begin
              state_d = ST_T1;
              cause_d = CAUSE_IRQ;
              brk_d   = 1'b0;
            end else if (brk_req_i) begin
              state_d = ST_T1;
              cause_d = CAUSE_IRQ;
              brk_d   = 1'b1;
            end
          end
        end
        ST_RES_HOLD: begin
          if (!res_low) begin
            state_d = ST_T1;
            cause_d = CAUSE_RES;
            brk_d   = 1'b0;
          end
        end
        ST_T1: state_d = ST_T2;
        ST_T2: state_d = ST_T3;
        ST_T3: state_d = ST_T4;
        ST_T4: state_d = ST_T5;
        ST_T5: state_d = ST_T6;
        ST_T6: state_d = ST_T7;
        ST_T7: begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // A qualified reset overrides everything, including a stalled rdy.
    if (res_qual) begin
      state_d = ST_RES_HOLD;
      cause_d = CAUSE_RES;
      brk_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge fclk_i) begin
    if (rst_i) begin
      state_q     <= ST_RES_HOLD;
      cause_q     <= CAUSE_RES;
      brk_q       <= 1'b0;
      done_q      <= 1'b0;
      nmi_pend_q  <= 1'b0;
      nmi_prev_q  <= 1'b1;
      resb_sync_q <= '1;
      nmib_sync_q <= '1;
      irqb_sync_q <= '1;
      res_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      brk_q       <= brk_d;
      done_q      <= done_d;
      nmi_pend_q  <= nmi_pend_d;
      nmi_prev_q  <= nmi_prev_d;
      resb_sync_q <= {resb_sync_q[SYNC_STAGES-2:0], resb_i};
      nmib_sync_q <= {nmib_sync_q[SYNC_STAGES-2:0], nmib_i};
      irqb_sync_q <= {irqb_sync_q[SYNC_STAGES-2:0], irqb_i};
      res_cnt_q   <= res_cnt_d;
    end
  end

  assign is_res     = (cause_q == CAUSE_RES);
  assign stack_push = ~is_res;

  // Moore outputs: reset sequences only read, interrupt sequences push PCH/PCL/PSR in T3-T5.
  always_comb begin
    busy_o         = 1'b0;
    seq_step_o     = 3'd0;
    cause_o        = CAUSE_NONE;
    rwb_o          = 1'b1;
    stack_sel_o    = 2'b00;
    sp_decrement_o = 1'b0;
    reset_stack_o  = 1'b0;
    psr_b_value_o  = 1'b0;
    set_i_flag_o   = 1'b0;
    clear_d_flag_o = 1'b0;
    vpb_o          = 1'b0;
    push_resb_o    = 1'b0;
    push_nmib_o    = 1'b0;
    push_irqb_o    = 1'b0;
    push_vector_o  = 1'b0;
    if (state_q == ST_RES_HOLD) begin
      busy_o  = 1'b1;
      cause_o = CAUSE_RES;
    end else if (state_q != ST_IDLE) begin
      busy_o        = 1'b1;
      cause_o       = cause_q;
      psr_b_value_o = brk_q;
    end
    unique case (state_q)
      ST_T1: seq_step_o = 3'd1;
      ST_T2: begin
        seq_step_o    = 3'd2;
        reset_stack_o = is_res;
      end
      ST_T3: begin
        seq_step_o     = 3'd3;
        sp_decrement_o = 1'b1;
        rwb_o          = ~stack_push;
        stack_sel_o    = stack_push ? 2'b01 : 2'b00;
      end
      ST_T4: begin
        seq_step_o     = 3'd4;
        sp_decrement_o = 1'b1;
        rwb_o          = ~stack_push;
        stack_sel_o    = stack_push ? 2'b10 : 2'b00;
      end
      ST_T5: begin
        seq_step_o     = 3'd5;
        sp_decrement_o = stack_push;
        rwb_o          = ~stack_push;
        stack_sel_o    = stack_push ? 2'b11 : 2'b00;
        set_i_flag_o   = 1'b1;
        clear_d_flag_o = 1'b1;
      end
      ST_T6: begin
        seq_step_o  = 3'd6;
        vpb_o       = 1'b1;
        push_resb_o = (cause_q == CAUSE_RES);
        push_nmib_o = (cause_q == CAUSE_NMI);
        push_irqb_o = (cause_q == CAUSE_IRQ);
      end
      ST_T7: begin
        seq_step_o    = 3'd7;
        vpb_o         = 1'b1;
        push_vector_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign seq_done_o    = done_q;
  assign nmi_pending_o = nmi_pend_q;
  assign irq_pending_o = irq_req;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: reset, NMI, IRQ masking, BRK, rdy stall and reset abort,
// each T-state compared against a hand-derived table of expected outputs.
module tb_interrupt_sequencer;

  localparam logic [1:0] CAUSE_RES = 2'b01;
  localparam logic [1:0] CAUSE_NMI = 2'b10;
  localparam logic [1:0] CAUSE_IRQ = 2'b11;
  localparam logic [31:0] HOLD_VEC = {13'b0, 1'b1, 3'd0, 2'b01, 1'b1, 12'b0};

  logic clk = 1'b0;
  logic rst, rdy, resb, nmib, irqb, iFlag, instrBoundary, brkReq;
  logic busy, rwb, spDecrement, resetStack, psrBValue, setIFlag, clearDFlag, vpb;
  logic pushResb, pushNmib, pushIrqb, pushVector, seqDone, nmiPending, irqPending;
  logic [2:0] seqStep;
  logic [1:0] cause, stackSel;

  int compareCount = 0;
  int mismatchCount = 0;

  always #5 clk = ~clk;

  interrupt_sequencer dut (
    .fclk_i(clk), .rst_i(rst), .rdy_i(rdy), .resb_i(resb), .nmib_i(nmib), .irqb_i(irqb),
    .i_flag_i(iFlag), .instr_boundary_i(instrBoundary), .brk_req_i(brkReq),
    .busy_o(busy), .seq_step_o(seqStep), .cause_o(cause), .rwb_o(rwb), .stack_sel_o(stackSel),
    .sp_decrement_o(spDecrement), .reset_stack_o(resetStack), .psr_b_value_o(psrBValue),
    .set_i_flag_o(setIFlag), .clear_d_flag_o(clearDFlag), .vpb_o(vpb),
    .push_resb_o(pushResb), .push_nmib_o(pushNmib), .push_irqb_o(pushIrqb),
    .push_vector_o(pushVector), .seq_done_o(seqDone), .nmi_pending_o(nmiPending),
    .irq_pending_o(irqPending)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One boundary cycle with optional BRK fetch; inputs return low afterwards.
  task automatic applyStimulus(input logic boundary, input logic brk);
    instrBoundary = boundary;
    brkReq = brk;
    tick();
    instrBoundary = 1'b0;
    brkReq = 1'b0;
  endtask

  function automatic logic [31:0] obsVec();
    return {13'b0, busy, seqStep, cause, rwb, stackSel, spDecrement, resetStack, psrBValue,
            setIFlag, clearDFlag, vpb, pushResb, pushNmib, pushIrqb, pushVector};
  endfunction

  // Expected outputs for T-state 'step' (0 = idle) of a sequence with the given cause and B bit.
  function automatic logic [31:0] expVec(input int step, input logic [1:0] cs, input logic b);
    logic isRes, push, bz, spd;
    logic [1:0] sel, c;
    isRes = (cs == CAUSE_RES);
    push = !isRes && step >= 3 && step <= 5;
    bz = (step != 0);
    c = bz ? cs : 2'b00;
    sel = push ? 2'(step - 2) : 2'b00;
    spd = isRes ? (step == 3 || step == 4) : push;
    return {13'b0, bz, 3'(step), c, !push, sel, spd, isRes && step == 2, bz && b,
            step == 5, step == 5, step == 6 || step == 7,
            step == 6 && cs == CAUSE_RES, step == 6 && cs == CAUSE_NMI,
            step == 6 && cs == CAUSE_IRQ, step == 7};
  endfunction

  // Called with the DUT sitting in T1; walks T1..T7 and the seq_done cycle.
  task automatic runSequence(input string name, input logic [1:0] cs, input logic b);
    for (int s = 1; s <= 7; s++) begin
      checkOutput($sformatf("%s_T%0d", name, s), obsVec(), expVec(s, cs, b));
      tick();
    end
    checkOutput({name, "_doneIdle"}, obsVec(), expVec(0, cs, b));
    checkOutput({name, "_done"}, 32'(seqDone), 32'd1);
    tick();
    checkOutput({name, "_doneClr"}, 32'(seqDone), 32'd0);
  endtask

  // Watchdog so a stuck simulation still terminates with a report.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;
    rst = 1'b1; rdy = 1'b1; resb = 1'b1; nmib = 1'b1; irqb = 1'b1;
    iFlag = 1'b1; instrBoundary = 1'b0; brkReq = 1'b0;

    // Reset held 3 cycles, then the reset sequence starts on the first released edge.
    repeat (3) tick();
    checkOutput("rstHold", obsVec(), HOLD_VEC);
    checkOutput("rstNmiPend", 32'(nmiPending), 32'd0);
    checkOutput("rstIrqPend", 32'(irqPending), 32'd0);
    checkOutput("rstDone", 32'(seqDone), 32'd0);
    rst = 1'b0;
    tick();
    runSequence("reset", CAUSE_RES, 1'b0);

    // NMI edge: two synchroniser stages, then pending latches.
    nmib = 1'b0;
    repeat (2) tick();
    checkOutput("nmiPendEarly", 32'(nmiPending), 32'd0);
    tick();
    checkOutput("nmiPendSet", 32'(nmiPending), 32'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("nmiPendClr", 32'(nmiPending), 32'd0);
    runSequence("nmi", CAUSE_NMI, 1'b0);
    nmib = 1'b1;

    // IRQ masked by I, then taken once I clears; irqb released mid-sequence.
    irqb = 1'b0;
    repeat (3) tick();
    checkOutput("irqMasked", 32'(irqPending), 32'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("irqNoStart", obsVec(), expVec(0, CAUSE_IRQ, 1'b0));
    iFlag = 1'b0;
    #1;
    checkOutput("irqPend", 32'(irqPending), 32'd1);
    applyStimulus(1'b1, 1'b0);
    irqb = 1'b1;
    runSequence("irq", CAUSE_IRQ, 1'b0);
    iFlag = 1'b1;

    // BRK alone, then BRK coinciding with an NMI edge.
    applyStimulus(1'b1, 1'b1);
    runSequence("brk", CAUSE_IRQ, 1'b1);
    nmib = 1'b0;
    repeat (3) tick();
    applyStimulus(1'b1, 1'b1);
    runSequence("brkNmi", CAUSE_NMI, 1'b0);
    nmib = 1'b1;

    // rdy low for three cycles while in T4.
    applyStimulus(1'b1, 1'b1);
    repeat (3) tick();
    checkOutput("stallT4", obsVec(), expVec(4, CAUSE_IRQ, 1'b1));
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("stallHold%0d", i), obsVec(), expVec(4, CAUSE_IRQ, 1'b1));
    end
    rdy = 1'b1;
    tick();
    checkOutput("stallT5", obsVec(), expVec(5, CAUSE_IRQ, 1'b1));
    tick();
    checkOutput("stallT6", obsVec(), expVec(6, CAUSE_IRQ, 1'b1));
    tick();
    tick();
    checkOutput("stallDone", 32'(seqDone), 32'd1);

    // resb pulsed low for two cycles during an IRQ sequence aborts into RES_HOLD.
    irqb = 1'b0;
    iFlag = 1'b0;
    repeat (3) tick();
    applyStimulus(1'b1, 1'b0);
    tick();
    tick();
    checkOutput("abortT3", obsVec(), expVec(3, CAUSE_IRQ, 1'b0));
    irqb = 1'b1;
    resb = 1'b0;
    tick();
    tick();
    resb = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (busy && seqStep == 3'd0) found = 1'b1;
    end
    checkOutput("abortReached", 32'(found), 32'd1);
    checkOutput("abortHold", obsVec(), HOLD_VEC);
    iFlag = 1'b1;
    tick();
    runSequence("abortReset", CAUSE_RES, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
